// File: rtl/mbist_pkg.sv
// Shared March C- definitions: element indices, controller states and per-element op table.
package mbist_pkg;

  localparam int unsigned EW = 3;

  typedef logic [EW-1:0] elem_t;

  localparam elem_t M0 = 3'd0;
  localparam elem_t M1 = 3'd1;
  localparam elem_t M2 = 3'd2;
  localparam elem_t M3 = 3'd3;
  localparam elem_t M4 = 3'd4;
  localparam elem_t M5 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic dir_down;  // address sweep wcount-1 -> 0
    logic has_rd;    // element starts with a read
    logic has_wr;    // element ends with a write
    logic rd_ones;   // read expects D1
    logic wr_ones;   // write stores D1
  } elem_cfg_t;

  // Indexed by element; entries 6 and 7 are unreachable.
  localparam elem_cfg_t ELEM_CFG [8] = '{
    '{dir_down: 1'b0, has_rd: 1'b0, has_wr: 1'b1, rd_ones: 1'b0, wr_ones: 1'b0},
    '{dir_down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_ones: 1'b0, wr_ones: 1'b1},
    '{dir_down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_ones: 1'b1, wr_ones: 1'b0},
    '{dir_down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_ones: 1'b0, wr_ones: 1'b1},
    '{dir_down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_ones: 1'b1, wr_ones: 1'b0},
    '{dir_down: 1'b0, has_rd: 1'b1, has_wr: 1'b0, rd_ones: 1'b0, wr_ones: 1'b0},
    '{dir_down: 1'b0, has_rd: 1'b0, has_wr: 1'b0, rd_ones: 1'b0, wr_ones: 1'b0},
    '{dir_down: 1'b0, has_rd: 1'b0, has_wr: 1'b0, rd_ones: 1'b0, wr_ones: 1'b0}
  };

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Read-latency delay line that aligns expected data with RAM dataout, compares it,
// and keeps a sticky fail flag, saturating miscompare count and first-failure capture.
module mbist_cmp_pipe
  import mbist_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 4,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_expected,
  input  logic [AW-1:0] in_addr,
  input  elem_t         in_elem,
  input  logic [DW-1:0] rd_data,
  output logic          fail,
  output logic [15:0]   fail_count,
  output logic [AW-1:0] fail_addr,
  output elem_t         fail_element,
  output logic [DW-1:0] fail_expected,
  output logic [DW-1:0] fail_actual
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DW-1:0]     exp_q  [RD_LAT];
  logic [DW-1:0]     exp_d  [RD_LAT];
  logic [AW-1:0]     addr_q [RD_LAT];
  logic [AW-1:0]     addr_d [RD_LAT];
  elem_t             elem_q [RD_LAT];
  elem_t             elem_d [RD_LAT];

  logic          fail_q, fail_d;
  logic [15:0]   fail_count_q, fail_count_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  elem_t         fail_element_q, fail_element_d;
  logic [DW-1:0] fail_expected_q, fail_expected_d;
  logic [DW-1:0] fail_actual_q, fail_actual_d;
  logic          mis_c;

  // Delay line: stage 0 holds the read the RAM is sampling this cycle.
  always_comb begin
    vld_d     = {vld_q[RD_LAT-2:0], in_valid};
    exp_d[0]  = in_expected;
    addr_d[0] = in_addr;
    elem_d[0] = in_elem;
    for (int i = 1; i < RD_LAT; i++) begin
      exp_d[i]  = exp_q[i-1];
      addr_d[i] = addr_q[i-1];
      elem_d[i] = elem_q[i-1];
    end
  end

  assign mis_c = vld_q[RD_LAT-1] && (rd_data != exp_q[RD_LAT-1]);

  always_comb begin
    fail_d          = fail_q;
    fail_count_d    = fail_count_q;
    fail_addr_d     = fail_addr_q;
    fail_element_d  = fail_element_q;
    fail_expected_d = fail_expected_q;
    fail_actual_d   = fail_actual_q;
    if (clr) begin
      fail_d          = 1'b0;
      fail_count_d    = '0;
      fail_addr_d     = '0;
      fail_element_d  = '0;
      fail_expected_d = '0;
      fail_actual_d   = '0;
    end else if (mis_c) begin
      fail_d = 1'b1;
      if (fail_count_q != 16'hFFFF) fail_count_d = fail_count_q + 16'd1;
      if (!fail_q) begin
        fail_addr_d     = addr_q[RD_LAT-1];
        fail_element_d  = elem_q[RD_LAT-1];
        fail_expected_d = exp_q[RD_LAT-1];
        fail_actual_d   = rd_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_q[i]  <= '0;
        addr_q[i] <= '0;
        elem_q[i] <= '0;
      end
      fail_q          <= 1'b0;
      fail_count_q    <= '0;
      fail_addr_q     <= '0;
      fail_element_q  <= '0;
      fail_expected_q <= '0;
      fail_actual_q   <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_q[i]  <= exp_d[i];
        addr_q[i] <= addr_d[i];
        elem_q[i] <= elem_d[i];
      end
      fail_q          <= fail_d;
      fail_count_q    <= fail_count_d;
      fail_addr_q     <= fail_addr_d;
      fail_element_q  <= fail_element_d;
      fail_expected_q <= fail_expected_d;
      fail_actual_q   <= fail_actual_d;
    end
  end

  assign fail          = fail_q;
  assign fail_count    = fail_count_q;
  assign fail_addr     = fail_addr_q;
  assign fail_element  = fail_element_q;
  assign fail_expected = fail_expected_q;
  assign fail_actual   = fail_actual_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST engine for single_port_ram: one registered RAM op per clock,
// read checking through mbist_cmp_pipe, pass/fail with first-failure capture.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int unsigned wcount  = 256,
  parameter int unsigned wlength = 4,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [$clog2(wcount)-1:0] sram_addr,
  output logic [wlength-1:0]        sram_datain,
  output logic                      sram_we,
  input  logic [wlength-1:0]        sram_dataout,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [15:0]               fail_count,
  output logic [$clog2(wcount)-1:0] fail_addr,
  output logic [2:0]                fail_element,
  output logic [wlength-1:0]        fail_expected,
  output logic [wlength-1:0]        fail_actual
);

  localparam int unsigned AW  = $clog2(wcount);
  localparam int unsigned DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(wcount - 1);

  state_t               state_q, state_d;
  elem_t                elem_q, elem_d;
  logic                 phase_q, phase_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 we_q, we_d;
  logic [wlength-1:0]   datain_q, datain_d;
  logic                 rd_q, rd_d;
  logic [wlength-1:0]   exp_q, exp_d;
  logic [DCW-1:0]       drain_q, drain_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 start_acc_c;
  logic                 term_c;

  // Terminal address depends on the sweep direction of the current element.
  assign term_c = ELEM_CFG[elem_q].dir_down ? (addr_q == '0) : (addr_q == ADDR_LAST);

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    drain_d     = drain_q;
    start_acc_c = 1'b0;
    we_d        = 1'b0;
    datain_d    = '0;
    rd_d        = 1'b0;
    exp_d       = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc_c = 1'b1;
          state_d     = ST_RUN;
          elem_d      = M0;
          phase_d     = 1'b0;
          addr_d      = '0;
        end
      end
      ST_RUN: begin
        if (!phase_q && ELEM_CFG[elem_q].has_rd && ELEM_CFG[elem_q].has_wr) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!term_c) begin
            addr_d = ELEM_CFG[elem_q].dir_down ? AW'(addr_q - 1'b1) : AW'(addr_q + 1'b1);
          end else if (elem_q == M5) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            elem_d = elem_t'(elem_q + 3'd1);
            addr_d = ELEM_CFG[elem_d].dir_down ? ADDR_LAST : '0;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DCW'(RD_LAT - 1)) state_d = ST_DONE;
        else                             drain_d = DCW'(drain_q + 1'b1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Op to drive next cycle, decoded from the next position.
    if (state_d == ST_RUN) begin
      we_d     = phase_d || !ELEM_CFG[elem_d].has_rd;
      rd_d     = !we_d;
      datain_d = we_d ? {wlength{ELEM_CFG[elem_d].wr_ones}} : '0;
      exp_d    = {wlength{ELEM_CFG[elem_d].rd_ones}};
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      elem_q   <= M0;
      phase_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      datain_q <= '0;
      rd_q     <= 1'b0;
      exp_q    <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      datain_q <= datain_d;
      rd_q     <= rd_d;
      exp_q    <= exp_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sram_addr   = addr_q;
  assign sram_we     = we_q;
  assign sram_datain = datain_q;
  assign busy        = busy_q;
  assign done        = done_q;

  mbist_cmp_pipe #(
    .AW     (AW),
    .DW     (wlength),
    .RD_LAT (RD_LAT)
  ) u_cmp_pipe (
    .clk           (clk),
    .rst           (rst),
    .clr           (start_acc_c),
    .in_valid      (rd_q),
    .in_expected   (exp_q),
    .in_addr       (addr_q),
    .in_elem       (elem_q),
    .rd_data       (sram_dataout),
    .fail          (fail),
    .fail_count    (fail_count),
    .fail_addr     (fail_addr),
    .fail_element  (fail_element),
    .fail_expected (fail_expected),
    .fail_actual   (fail_actual)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl against a 2-cycle-latency RAM model with stuck-at masks.
module tb_mbist_march_ctrl;

  localparam int unsigned WC  = 16;
  localparam int unsigned WL  = 4;
  localparam int unsigned LOG = 200;

  logic          clk;
  logic          rst;
  logic          start;
  logic [3:0]    sram_addr;
  logic [WL-1:0] sram_datain;
  logic          sram_we;
  logic [WL-1:0] sram_dataout;
  logic          busy;
  logic          done;
  logic          fail;
  logic [15:0]   fail_count;
  logic [3:0]    fail_addr;
  logic [2:0]    fail_element;
  logic [WL-1:0] fail_expected;
  logic [WL-1:0] fail_actual;

  int n_checks = 0;
  int n_errors = 0;

  logic [WL-1:0] ram1 [WC];
  logic [WL-1:0] sa0  [WC];
  logic [WL-1:0] sa1  [WC];
  logic [WL-1:0] rd_s1, rd_s2;

  logic [3:0]    log_addr [LOG];
  logic          log_we   [LOG];
  logic [WL-1:0] log_din  [LOG];

  int   done_at;
  int   wr_cnt;
  logic fail_k0;
  logic [15:0] cnt_k0;

  mbist_march_ctrl #(.wcount(WC), .wlength(WL), .RD_LAT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sram_addr     (sram_addr),
    .sram_datain   (sram_datain),
    .sram_we       (sram_we),
    .sram_dataout  (sram_dataout),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .fail_count    (fail_count),
    .fail_addr     (fail_addr),
    .fail_element  (fail_element),
    .fail_expected (fail_expected),
    .fail_actual   (fail_actual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: addr sampled at an edge, data valid after the second following edge.
  always @(posedge clk) begin
    if (sram_we) ram1[sram_addr] <= (sram_datain & ~sa0[sram_addr]) | sa1[sram_addr];
    rd_s1 <= (ram1[sram_addr] & ~sa0[sram_addr]) | sa1[sram_addr];
    rd_s2 <= rd_s1;
  end
  assign sram_dataout = rd_s2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < WC; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
  endtask

  // Pulses start (sampled at E0), then samples #1 after each edge; k = edges since E0.
  task automatic run_march(input int repulse_at, output int d_at, output int wrs,
                           output logic f0, output logic [15:0] c0);
    d_at = -1;
    wrs  = 0;
    f0   = 1'b1;
    c0   = 16'hDEAD;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (k == 0) begin
        f0 = fail;
        c0 = fail_count;
      end
      if (k < LOG) begin
        log_addr[k] = sram_addr;
        log_we[k]   = sram_we;
        log_din[k]  = sram_datain;
      end
      if (sram_we) wrs++;
      if (done) begin
        d_at = k;
        break;
      end
      if (k == repulse_at) start = 1'b1;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clear_faults();

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fail", 32'(fail), 32'd0);
    check_eq("rst_fail_count", 32'(fail_count), 32'd0);
    check_eq("rst_sram_we", 32'(sram_we), 32'd0);
    check_eq("rst_sram_addr", 32'(sram_addr), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_no_start_busy", 32'(busy), 32'd0);

    // Clean run with op-sequence spot checks.
    run_march(-1, done_at, wr_cnt, fail_k0, cnt_k0);
    check_eq("clean_done_at", 32'(done_at), 32'd162);
    check_eq("clean_busy_at_done", 32'(busy), 32'd0);
    check_eq("clean_fail", 32'(fail), 32'd0);
    check_eq("clean_fail_count", 32'(fail_count), 32'd0);
    check_eq("clean_writes", 32'(wr_cnt), 32'd80);
    check_eq("op0_we", 32'(log_we[0]), 32'd1);
    check_eq("op16_addr", 32'(log_addr[16]), 32'd0);
    check_eq("op16_we", 32'(log_we[16]), 32'd0);
    check_eq("op17_addr", 32'(log_addr[17]), 32'd0);
    check_eq("op17_we", 32'(log_we[17]), 32'd1);
    check_eq("op17_din", 32'(log_din[17]), 32'hF);
    check_eq("op48_addr", 32'(log_addr[48]), 32'd0);
    check_eq("op48_we", 32'(log_we[48]), 32'd0);
    check_eq("op49_din", 32'(log_din[49]), 32'h0);
    check_eq("op80_addr", 32'(log_addr[80]), 32'd15);
    check_eq("op80_we", 32'(log_we[80]), 32'd0);
    check_eq("op81_addr", 32'(log_addr[81]), 32'd15);
    check_eq("op81_we", 32'(log_we[81]), 32'd1);
    check_eq("op81_din", 32'(log_din[81]), 32'hF);
    check_eq("op159_addr", 32'(log_addr[159]), 32'd15);
    check_eq("op160_we", 32'(log_we[160]), 32'd0);

    // start during RUN is ignored.
    run_march(30, done_at, wr_cnt, fail_k0, cnt_k0);
    check_eq("repulse_done_at", 32'(done_at), 32'd162);
    check_eq("repulse_writes", 32'(wr_cnt), 32'd80);

    // Stuck-at-0 on bit 0 of word 5.
    sa0[5] = 4'h1;
    run_march(-1, done_at, wr_cnt, fail_k0, cnt_k0);
    check_eq("sa0_done_at", 32'(done_at), 32'd162);
    check_eq("sa0_fail", 32'(fail), 32'd1);
    check_eq("sa0_fail_count", 32'(fail_count), 32'd2);
    check_eq("sa0_fail_addr", 32'(fail_addr), 32'd5);
    check_eq("sa0_fail_element", 32'(fail_element), 32'd2);
    check_eq("sa0_fail_expected", 32'(fail_expected), 32'hF);
    check_eq("sa0_fail_actual", 32'(fail_actual), 32'hE);

    // Restart from DONE after a failing run clears the fail state.
    clear_faults();
    run_march(-1, done_at, wr_cnt, fail_k0, cnt_k0);
    check_eq("restart_fail_cleared", 32'(fail_k0), 32'd0);
    check_eq("restart_count_cleared", 32'(cnt_k0), 32'd0);
    check_eq("restart_done_at", 32'(done_at), 32'd162);
    check_eq("restart_fail", 32'(fail), 32'd0);

    // Reset mid-run with a fault already recorded.
    for (int i = 3; i <= 10; i++) begin
      sa0[i] = 4'h1;
      sa1[i] = 4'h2;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check_eq("pre_rst_fail", 32'(fail), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_fail", 32'(fail), 32'd0);
    check_eq("async_rst_fail_count", 32'(fail_count), 32'd0);
    check_eq("async_rst_fail_addr", 32'(fail_addr), 32'd0);
    check_eq("async_rst_fail_element", 32'(fail_element), 32'd0);
    check_eq("async_rst_sram_addr", 32'(sram_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_idle_busy", 32'(busy), 32'd0);
    check_eq("post_rst_idle_done", 32'(done), 32'd0);

    clear_faults();
    run_march(-1, done_at, wr_cnt, fail_k0, cnt_k0);
    check_eq("post_rst_done_at", 32'(done_at), 32'd162);
    check_eq("post_rst_fail", 32'(fail), 32'd0);

    // Eight words with bit0 stuck-at-0 and bit1 stuck-at-1: five miscompares each.
    for (int i = 3; i <= 10; i++) begin
      sa0[i] = 4'h1;
      sa1[i] = 4'h2;
    end
    run_march(-1, done_at, wr_cnt, fail_k0, cnt_k0);
    check_eq("multi_done_at", 32'(done_at), 32'd162);
    check_eq("multi_fail", 32'(fail), 32'd1);
    check_eq("multi_fail_count", 32'(fail_count), 32'd40);
    check_eq("multi_fail_addr", 32'(fail_addr), 32'd3);
    check_eq("multi_fail_element", 32'(fail_element), 32'd1);
    check_eq("multi_fail_expected", 32'(fail_expected), 32'h0);
    check_eq("multi_fail_actual", 32'(fail_actual), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
